// File: rtl/tc_dbuf_ctrl.sv
// tc_dbuf_ctrl: sequences one output block through the D/C tile buffer.
// Loads N_ROWS rows of C, runs K passes of tensor-core read-modify-write over
// every tile, then drains N_ROWS rows back to memory.
module tc_dbuf_ctrl #(
  parameter int N_ROWS   = 16,
  parameter int NUM_TILE = 16,
  parameter int DW_COL   = 4,
  parameter int DW_K     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DW_K-1:0]   k_iters,
  output logic              busy,
  output logic              done,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              write_outside_en,
  output logic [DW_COL-1:0] row_in,
  output logic              tc_req,
  input  logic              tc_ack,
  input  logic              tc_done,
  output logic [DW_COL-1:0] ptr_out,
  output logic              write_inside_en,
  output logic [DW_COL-1:0] ptr_in,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [DW_COL-1:0] row_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [DW_COL-1:0] ROW_LAST  = DW_COL'(N_ROWS - 1);
  localparam logic [DW_COL-1:0] TILE_LAST = DW_COL'(NUM_TILE - 1);
  localparam logic [DW_K-1:0]   K_ONE     = DW_K'(1);

  state_t            state, state_nxt;
  logic [DW_COL-1:0] row, row_nxt;
  logic [DW_COL-1:0] tile, tile_nxt;
  logic [DW_K-1:0]   iter, iter_nxt;
  logic [DW_K-1:0]   k_reg, k_nxt;

  // State and counter registers; reset drops straight back to IDLE with clean counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row   <= '0;
      tile  <= '0;
      iter  <= '0;
      k_reg <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      tile  <= tile_nxt;
      iter  <= iter_nxt;
      k_reg <= k_nxt;
    end
  end

  // Next-state and counter update; counters are returned to 0 at each phase end
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    tile_nxt  = tile;
    iter_nxt  = iter;
    k_nxt     = k_reg;
    unique case (state)
      IDLE: begin
        if (start) begin
          k_nxt     = k_iters;
          row_nxt   = '0;
          tile_nxt  = '0;
          iter_nxt  = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          if (row == ROW_LAST) begin
            row_nxt   = '0;
            state_nxt = (k_reg == '0) ? DRAIN : ISSUE;
          end else begin
            row_nxt = row + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (tc_ack) state_nxt = WAIT;
      end
      WAIT: begin
        if (tc_done) begin
          if (tile != TILE_LAST) begin
            tile_nxt  = tile + 1'b1;
            state_nxt = ISSUE;
          end else if (iter != (k_reg - K_ONE)) begin
            tile_nxt  = '0;
            iter_nxt  = iter + K_ONE;
            state_nxt = ISSUE;
          end else begin
            tile_nxt  = '0;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (st_ready) begin
          if (row == ROW_LAST) begin
            row_nxt   = '0;
            state_nxt = DONE;
          end else begin
            row_nxt = row + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode; strobes depend only on the current state and the live handshake inputs
  always_comb begin
    busy             = (state != IDLE);
    done             = (state == DONE);
    ld_ready         = (state == LOAD);
    write_outside_en = (state == LOAD) && ld_valid;
    row_in           = row;
    tc_req           = (state == ISSUE);
    ptr_out          = tile;
    write_inside_en  = (state == WAIT) && tc_done;
    ptr_in           = tile;
    st_valid         = (state == DRAIN);
    row_out          = row;
  end

endmodule

// File: tb/tb_tc_dbuf_ctrl.sv
// tb_tc_dbuf_ctrl: directed bench for the tile-buffer sequencer.
// A responder plays memory and tensor core; a monitor logs strobes and indices.
module tb_tc_dbuf_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] k_iters = '0;
  logic       busy, done;
  logic       ld_valid = 1'b0, ld_ready, write_outside_en;
  logic [3:0] row_in;
  logic       tc_req, tc_ack = 1'b0, tc_done = 1'b0;
  logic [3:0] ptr_out, ptr_in;
  logic       write_inside_en;
  logic       st_valid, st_ready = 1'b0;
  logic [3:0] row_out;

  tc_dbuf_ctrl #(.N_ROWS(16), .NUM_TILE(16), .DW_COL(4), .DW_K(8)) dut (
    .clk(clk), .reset(reset), .start(start), .k_iters(k_iters),
    .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .write_outside_en(write_outside_en), .row_in(row_in),
    .tc_req(tc_req), .tc_ack(tc_ack), .tc_done(tc_done),
    .ptr_out(ptr_out), .write_inside_en(write_inside_en), .ptr_in(ptr_in),
    .st_valid(st_valid), .st_ready(st_ready), .row_out(row_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder configuration
  bit ld_rand = 0, st_rand = 0, glitch = 0;
  int done_delay = 0, ack_delay = 0;
  bit pending = 0, prev_hs = 0, issue_seen = 0, in_wait = 0, wait_done = 0;
  int wcnt = 0, acnt = 0;

  // Monitor records
  int tcnt = 0;
  int ld_rows[$], wr_tiles[$], dr_rows[$];
  int tcreq_cnt, done_cnt, done_t, last_load_t, first_drain_t;
  int stab_err, ptr_err, both_err, wr_bad;
  logic       prev_stv = 0, prev_str = 0, prev_wait = 0;
  logic [3:0] prev_rowout = '0, prev_ptr = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [22:0] allOutputs();
    return {busy, done, ld_ready, write_outside_en, tc_req, write_inside_en, st_valid,
            row_in, ptr_out, ptr_in, row_out};
  endfunction

  // Memory and tensor-core responder, driven on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        pending = 0; prev_hs = 0; issue_seen = 0; in_wait = 0;
        tc_ack = 0; tc_done = 0; ld_valid = 0; st_ready = 0;
      end else begin
        ld_valid = ld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        st_ready = st_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (prev_hs) begin
          pending = 1;
          wcnt = done_delay;
        end
        in_wait = pending;
        wait_done = 0;
        if (pending) begin
          if (wcnt == 0) begin
            wait_done = 1;
            pending = 0;
          end else begin
            wcnt--;
          end
        end
        if (tc_req) begin
          if (!issue_seen) begin
            issue_seen = 1;
            acnt = ack_delay;
          end else if (acnt > 0) begin
            acnt--;
          end
          tc_ack = (acnt == 0);
        end else begin
          issue_seen = 0;
          tc_ack = 0;
        end
        tc_done = wait_done || (glitch && tc_req && !tc_ack);
        prev_hs = tc_req && tc_ack;
      end
    end
  end

  // Monitor, sampling 1 time unit after the inputs settle
  initial begin
    forever begin
      @(negedge clk);
      #1;
      tcnt++;
      if (reset) begin
        if (write_outside_en) begin
          ld_rows.push_back(int'(row_in));
          last_load_t = tcnt;
        end
        if (write_inside_en) begin
          wr_tiles.push_back(int'(ptr_in));
          if (tc_req || ptr_in != ptr_out) wr_bad++;
        end
        if (write_outside_en && write_inside_en) both_err++;
        if (tc_req) tcreq_cnt++;
        if (st_valid && first_drain_t < 0) first_drain_t = tcnt;
        if (st_valid && st_ready) dr_rows.push_back(int'(row_out));
        if (prev_stv && !prev_str && (!st_valid || row_out != prev_rowout)) stab_err++;
        if (prev_wait && in_wait && ptr_out != prev_ptr) ptr_err++;
        if (done) begin
          done_cnt++;
          done_t = tcnt;
        end
      end
      prev_stv    = st_valid && reset;
      prev_str    = st_ready;
      prev_rowout = row_out;
      prev_wait   = in_wait && reset;
      prev_ptr    = ptr_out;
    end
  end

  task automatic clearMonitor();
    ld_rows.delete(); wr_tiles.delete(); dr_rows.delete();
    tcreq_cnt = 0; done_cnt = 0; done_t = -1; last_load_t = -1; first_drain_t = -1;
    stab_err = 0; ptr_err = 0; both_err = 0; wr_bad = 0;
  endtask

  task automatic applyStimulus(input int k, input bit ldr, input bit str, input int dly,
                               input int ackd, input bit glt, input bit extra_starts,
                               output int rel_done);
    int start_t;
    ld_rand = ldr; st_rand = str; done_delay = dly; ack_delay = ackd; glitch = glt;
    clearMonitor();
    @(negedge clk);
    start = 1'b1;
    k_iters = 8'(k);
    #2;
    start_t = tcnt;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (extra_starts) start = (c >= 3 && c < 9);
      #2;
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(done_cnt > 0), 1);
    @(negedge clk);
    #2;
    checkOutput("busy_after_done", 32'(busy), 0);
    @(negedge clk);
    #2;
    rel_done = done_t - start_t + 1;
  endtask

  task automatic checkBlock(input string name, input int k);
    int e;
    checkOutput({name, ".load_count"}, ld_rows.size(), 16);
    e = 0;
    foreach (ld_rows[i]) if (ld_rows[i] != i) e++;
    checkOutput({name, ".load_order"}, e, 0);
    checkOutput({name, ".tile_writes"}, wr_tiles.size(), 16 * k);
    e = 0;
    foreach (wr_tiles[i]) if (wr_tiles[i] != (i % 16)) e++;
    checkOutput({name, ".tile_order"}, e, 0);
    checkOutput({name, ".drain_count"}, dr_rows.size(), 16);
    e = 0;
    foreach (dr_rows[i]) if (dr_rows[i] != i) e++;
    checkOutput({name, ".drain_order"}, e, 0);
    checkOutput({name, ".done_pulse"}, done_cnt, 1);
    checkOutput({name, ".write_overlap"}, both_err, 0);
    checkOutput({name, ".write_in_issue"}, wr_bad, 0);
    checkOutput({name, ".drain_stable"}, stab_err, 0);
    checkOutput({name, ".ptr_stable"}, ptr_err, 0);
  endtask

  // Directed test sequence
  initial begin
    int rel;
    bit found;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_outputs", 32'(allOutputs()), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] k=1 full rate");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, rel);
    checkBlock("t1", 1);
    checkOutput("t1.done_cycle", rel, 66);

    $display("[TB] k=3 with tc_done delayed 4 cycles");
    applyStimulus(3, 0, 0, 4, 0, 0, 0, rel);
    checkBlock("t2", 3);
    checkOutput("t2.done_cycle", rel, 322);

    $display("[TB] k=0 skips compute");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, rel);
    checkBlock("t3", 0);
    checkOutput("t3.tc_req_cycles", tcreq_cnt, 0);
    checkOutput("t3.drain_gap", first_drain_t - last_load_t, 1);
    checkOutput("t3.done_cycle", rel, 34);

    $display("[TB] random load/drain gaps");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, rel);
    checkBlock("t4", 1);

    $display("[TB] tc_done glitch during ISSUE");
    applyStimulus(1, 0, 0, 0, 2, 1, 0, rel);
    checkBlock("t6", 1);
    checkOutput("t6.done_cycle", rel, 98);

    $display("[TB] reset during WAIT at tile 7 iter 1");
    ld_rand = 0; st_rand = 0; done_delay = 4; ack_delay = 0; glitch = 0;
    clearMonitor();
    @(negedge clk);
    start = 1'b1;
    k_iters = 8'd3;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      #2;
      if (wr_tiles.size() == 23 && in_wait && !tc_done) found = 1;
    end
    checkOutput("t5.reached_wait", 32'(found), 1);
    checkOutput("t5.tile_at_abort", 32'(ptr_out), 7);
    reset = 1'b0;
    #1;
    checkOutput("t5.outputs_in_reset", 32'(allOutputs()), 0);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("t5.outputs_held", 32'(allOutputs()), 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 1, rel);
    checkBlock("t5b", 1);
    checkOutput("t5b.done_cycle", rel, 66);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
